// File: rtl/bp_resolve_queue_if.sv
// ---------------------------------------------------------------------------
// bp_resolve_queue_if
// Bundles the fetch-side push port, the execute-side resolve port, the
// predictor update port and the flush/status outputs of bp_resolve_queue.
//   PCW  : PC width in bits (INSTR_SIZE_BYTE*8)
//   CNTW : occupancy width, log2(DEPTH)+1
// Modports:
//   slave  : the queue itself (takes in_*, drives out_*)
//   master : the pipeline / bench side (drives in_*, takes out_*)
// Optional macro BP_RESOLVE_STATS_EN adds three 32-bit statistics counters.
// ---------------------------------------------------------------------------
interface bp_resolve_queue_if #(
  parameter int PCW  = 32,
  parameter int CNTW = 4
);
  // fetch side
  logic            in_fetch_nop;
  logic [PCW-1:0]  in_fetch_pc;
  logic            in_pred_taken;
  logic [PCW-1:0]  in_pred_offset;
  logic            out_fetch_stall;
  // resolve side
  logic            in_resolve_nop;
  logic            in_resolve_taken;
  logic [PCW-1:0]  in_resolve_offset;
  // predictor update
  logic            out_exe_nop;
  logic [PCW-1:0]  out_exe_pc;
  logic            out_exe_branch_taken;
  logic [PCW-1:0]  out_exe_branch_offset;
  // flush / status
  logic            out_flush;
  logic [PCW-1:0]  out_flush_pc;
  logic            out_underflow;
  logic [CNTW-1:0] out_count;
`ifdef BP_RESOLVE_STATS_EN
  logic [31:0]     out_pred_correct_cnt;
  logic [31:0]     out_pred_wrong_cnt;
  logic [31:0]     out_underflow_cnt;
`endif

  modport slave (
    input  in_fetch_nop, in_fetch_pc, in_pred_taken, in_pred_offset,
    input  in_resolve_nop, in_resolve_taken, in_resolve_offset,
    output out_fetch_stall,
    output out_exe_nop, out_exe_pc, out_exe_branch_taken, out_exe_branch_offset,
    output out_flush, out_flush_pc, out_underflow, out_count
`ifdef BP_RESOLVE_STATS_EN
    , output out_pred_correct_cnt, out_pred_wrong_cnt, out_underflow_cnt
`endif
  );

  modport master (
    output in_fetch_nop, in_fetch_pc, in_pred_taken, in_pred_offset,
    output in_resolve_nop, in_resolve_taken, in_resolve_offset,
    input  out_fetch_stall,
    input  out_exe_nop, out_exe_pc, out_exe_branch_taken, out_exe_branch_offset,
    input  out_flush, out_flush_pc, out_underflow, out_count
`ifdef BP_RESOLVE_STATS_EN
    , input out_pred_correct_cnt, out_pred_wrong_cnt, out_underflow_cnt
`endif
  );
endinterface

// File: rtl/bp_resolve_queue.sv
// ---------------------------------------------------------------------------
// bp_resolve_queue
// In-order queue of fetched branch predictions. Each resolve from execute pops
// the oldest prediction, drives the predictor update port and, when the
// prediction was wrong, pulses a flush with the redirect PC and spends
// FLUSH_CYCLES cycles in FLUSH with the queue emptied.
// Parameters: DEPTH (power of two, >=2), INSTR_SIZE_BYTE, FLUSH_CYCLES (>=1).
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : bp_resolve_queue_if.slave (fetch push, resolve, update, flush,
//           underflow, occupancy)
// Optional macro BP_RESOLVE_STATS_EN: saturating correct/wrong/underflow
// counters on the interface.
// All outputs are registered except out_fetch_stall.
// ---------------------------------------------------------------------------
module bp_resolve_queue #(
  parameter int DEPTH           = 8,
  parameter int INSTR_SIZE_BYTE = 4,
  parameter int FLUSH_CYCLES    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bp_resolve_queue_if.slave    bus
);
  localparam int PCW  = INSTR_SIZE_BYTE * 8;
  localparam int AW   = $clog2(DEPTH);
  localparam int PTRW = AW + 1;
  localparam int FCW  = $clog2(FLUSH_CYCLES + 1);
  localparam int EW   = 2 * PCW + 1;

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t           state_reg, state_next;
  logic [FCW-1:0]   flush_cnt_reg, flush_cnt_next;
  logic [PTRW-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PTRW-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [PTRW-1:0]  count_reg;

  // entry layout: {pc, pred_taken, pred_offset}
  logic [EW-1:0]    mem [DEPTH];

  logic             in_run;
  logic             full, empty;
  logic             push, pop, underflow_evt, mispredict;
  logic [PCW-1:0]   head_pc, head_offset;
  logic             head_taken;
  logic [PCW-1:0]   redirect_pc;

  // ---------------- datapath decode ----------------
  assign full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                 (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign empty = (wr_ptr_reg == rd_ptr_reg);

  assign {head_pc, head_taken, head_offset} = mem[rd_ptr_reg[AW-1:0]];

  // In FLUSH the queue is empty and resolves are ignored, so pop and
  // underflow are both gated by RUN.
  assign pop           = in_run && !bus.in_resolve_nop && !empty;
  assign underflow_evt = in_run && !bus.in_resolve_nop && empty;
  assign mispredict    = pop &&
                         ((head_taken != bus.in_resolve_taken) ||
                          (head_taken && bus.in_resolve_taken &&
                           (head_offset != bus.in_resolve_offset)));
  // A full queue still accepts a push when the head leaves in the same cycle;
  // a mispredict discards anything pushed alongside it.
  assign push = in_run && !bus.in_fetch_nop && (!full || pop) && !mispredict;

  assign redirect_pc = bus.in_resolve_taken ? (head_pc + bus.in_resolve_offset)
                                            : (head_pc + PCW'(INSTR_SIZE_BYTE));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_RUN;
      flush_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  // ---------------- FSM: next state ----------------
  // The counter is loaded with FLUSH_CYCLES-1 so that FLUSH occupies exactly
  // FLUSH_CYCLES cycles including the one in which it reads zero.
  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    case (state_reg)
      ST_RUN: begin
        if (mispredict) begin
          state_next     = ST_FLUSH;
          flush_cnt_next = FCW'(FLUSH_CYCLES - 1);
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_reg == '0) begin
          state_next = ST_RUN;
        end else begin
          flush_cnt_next = flush_cnt_reg - 1'b1;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_run              = (state_reg == ST_RUN);
    bus.out_fetch_stall = full || (state_reg == ST_FLUSH);
  end

  // ---------------- pointers ----------------
  always_comb begin
    wr_ptr_next = wr_ptr_reg + (push ? PTRW'(1) : PTRW'(0));
    rd_ptr_next = rd_ptr_reg + (pop  ? PTRW'(1) : PTRW'(0));
    if (mispredict) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= wr_ptr_next - rd_ptr_next;
    end
  end

  // Storage carries no reset: validity is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= {bus.in_fetch_pc, bus.in_pred_taken, bus.in_pred_offset};
    end
  end

  // ---------------- registered outputs ----------------
  // Update data and redirect PC hold their last value between events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_exe_nop           <= 1'b1;
      bus.out_exe_pc            <= '0;
      bus.out_exe_branch_taken  <= 1'b0;
      bus.out_exe_branch_offset <= '0;
      bus.out_flush             <= 1'b0;
      bus.out_flush_pc          <= '0;
      bus.out_underflow         <= 1'b0;
    end else begin
      bus.out_exe_nop   <= !pop;
      bus.out_flush     <= mispredict;
      bus.out_underflow <= underflow_evt;
      if (pop) begin
        bus.out_exe_pc            <= head_pc;
        bus.out_exe_branch_taken  <= bus.in_resolve_taken;
        bus.out_exe_branch_offset <= bus.in_resolve_offset;
      end
      if (mispredict) begin
        bus.out_flush_pc <= redirect_pc;
      end
    end
  end

  assign bus.out_count = count_reg;

`ifdef BP_RESOLVE_STATS_EN
  logic [31:0] correct_cnt_reg, wrong_cnt_reg, underflow_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      correct_cnt_reg   <= '0;
      wrong_cnt_reg     <= '0;
      underflow_cnt_reg <= '0;
    end else begin
      if (pop && !mispredict && (correct_cnt_reg != 32'hFFFF_FFFF))
        correct_cnt_reg <= correct_cnt_reg + 32'd1;
      if (mispredict && (wrong_cnt_reg != 32'hFFFF_FFFF))
        wrong_cnt_reg <= wrong_cnt_reg + 32'd1;
      if (underflow_evt && (underflow_cnt_reg != 32'hFFFF_FFFF))
        underflow_cnt_reg <= underflow_cnt_reg + 32'd1;
    end
  end

  assign bus.out_pred_correct_cnt = correct_cnt_reg;
  assign bus.out_pred_wrong_cnt   = wrong_cnt_reg;
  assign bus.out_underflow_cnt    = underflow_cnt_reg;
`endif

endmodule

// File: tb/tb_bp_resolve_queue.sv
// ---------------------------------------------------------------------------
// tb_bp_resolve_queue
// Directed stimulus for bp_resolve_queue. A queue-based reference model runs
// alongside the DUT and every output is compared on each falling edge; the
// directed sections add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_bp_resolve_queue;
  localparam int DEPTH = 8;
  localparam int IB    = 4;
  localparam int FC    = 2;
  localparam int PCW   = 32;
  localparam int CNTW  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  bp_resolve_queue_if #(.PCW(PCW), .CNTW(CNTW)) bus ();

  bp_resolve_queue #(
    .DEPTH(DEPTH), .INSTR_SIZE_BYTE(IB), .FLUSH_CYCLES(FC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] off;
  } ent_t;

  ent_t        m_q[$];
  int          m_flush_left = 0;
  logic        e_exe_nop = 1'b1;
  logic [31:0] e_pc = '0;
  logic        e_taken = 1'b0;
  logic [31:0] e_off = '0;
  logic        e_flush = 1'b0;
  logic [31:0] e_flush_pc = '0;
  logic        e_underflow = 1'b0;
  longint      m_correct = 0, m_wrong = 0, m_under = 0;

  task automatic model_reset();
    m_q.delete();
    m_flush_left = 0;
    e_exe_nop = 1'b1; e_pc = '0; e_taken = 1'b0; e_off = '0;
    e_flush = 1'b0; e_flush_pc = '0; e_underflow = 1'b0;
    m_correct = 0; m_wrong = 0; m_under = 0;
  endtask

  task automatic model_step();
    ent_t h, n;
    bit   was_full, popped, mis;
    e_flush = 1'b0;
    e_underflow = 1'b0;
    e_exe_nop = 1'b1;
    if (m_flush_left > 0) begin
      m_flush_left--;           // wrong-path fetches and resolves are dropped
    end else begin
      was_full = (m_q.size() == DEPTH);
      popped = 1'b0;
      mis = 1'b0;
      if (!bus.in_resolve_nop) begin
        if (m_q.size() == 0) begin
          e_underflow = 1'b1;
          m_under++;
        end else begin
          h = m_q.pop_front();
          popped = 1'b1;
          e_exe_nop = 1'b0;
          e_pc = h.pc;
          e_taken = bus.in_resolve_taken;
          e_off = bus.in_resolve_offset;
          mis = (h.taken != bus.in_resolve_taken) ||
                (h.taken && bus.in_resolve_taken && h.off != bus.in_resolve_offset);
          if (mis) begin
            e_flush = 1'b1;
            e_flush_pc = bus.in_resolve_taken ? h.pc + bus.in_resolve_offset : h.pc + 32'(IB);
            m_q.delete();
            m_flush_left = FC;
            m_wrong++;
          end else begin
            m_correct++;
          end
        end
      end
      if (!bus.in_fetch_nop && !mis && (!was_full || popped)) begin
        n.pc = bus.in_fetch_pc;
        n.taken = bus.in_pred_taken;
        n.off = bus.in_pred_offset;
        m_q.push_back(n);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("m_exe_nop",   64'(bus.out_exe_nop), 64'(e_exe_nop));
        chk("m_exe_pc",    64'(bus.out_exe_pc), 64'(e_pc));
        chk("m_exe_taken", 64'(bus.out_exe_branch_taken), 64'(e_taken));
        chk("m_exe_off",   64'(bus.out_exe_branch_offset), 64'(e_off));
        chk("m_flush",     64'(bus.out_flush), 64'(e_flush));
        chk("m_flush_pc",  64'(bus.out_flush_pc), 64'(e_flush_pc));
        chk("m_underflow", 64'(bus.out_underflow), 64'(e_underflow));
        chk("m_count",     64'(bus.out_count), 64'(m_q.size()));
        chk("m_stall",     64'(bus.out_fetch_stall),
            64'((m_q.size() == DEPTH) || (m_flush_left > 0)));
`ifdef BP_RESOLVE_STATS_EN
        chk("m_correct_cnt",   64'(bus.out_pred_correct_cnt), 64'(m_correct));
        chk("m_wrong_cnt",     64'(bus.out_pred_wrong_cnt), 64'(m_wrong));
        chk("m_underflow_cnt", 64'(bus.out_underflow_cnt), 64'(m_under));
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  // One call = one clock: inputs applied on the falling edge, result visible
  // at the next falling edge.
  task automatic cyc(input logic fnop, input logic [31:0] fpc, input logic pt,
                     input logic [31:0] po, input logic rnop, input logic rt,
                     input logic [31:0] ro);
    bus.in_fetch_nop      = fnop;
    bus.in_fetch_pc       = fpc;
    bus.in_pred_taken     = pt;
    bus.in_pred_offset    = po;
    bus.in_resolve_nop    = rnop;
    bus.in_resolve_taken  = rt;
    bus.in_resolve_offset = ro;
    @(posedge clk);
    @(negedge clk);
    $display("t=%0t fnop=%0b fpc=%h rnop=%0b rt=%0b ro=%h -> exe_nop=%0b pc=%h flush=%0b fpc=%h uf=%0b cnt=%0d stall=%0b",
             $time, fnop, fpc, rnop, rt, ro, bus.out_exe_nop, bus.out_exe_pc,
             bus.out_flush, bus.out_flush_pc, bus.out_underflow, bus.out_count,
             bus.out_fetch_stall);
  endtask

  task automatic idle();
    cyc(1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    bus.in_fetch_nop = 1'b1; bus.in_fetch_pc = '0; bus.in_pred_taken = 1'b0;
    bus.in_pred_offset = '0; bus.in_resolve_nop = 1'b1; bus.in_resolve_taken = 1'b0;
    bus.in_resolve_offset = '0;

    // reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_exe_nop", 64'(bus.out_exe_nop), 64'd1);
    chk("rst_count",   64'(bus.out_count), 64'd0);
    chk("rst_stall",   64'(bus.out_fetch_stall), 64'd0);
    chk("rst_flush",   64'(bus.out_flush), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // fill: 0x100..0x11C, predicted not-taken
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 32'h100 + 32'(4 * i), 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("fill_count", 64'(bus.out_count), 64'd8);
    chk("fill_stall", 64'(bus.out_fetch_stall), 64'd1);
    cyc(1'b0, 32'h120, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("fill_drop_count", 64'(bus.out_count), 64'd8);

    // full with same-cycle push and pop, 3*DEPTH times (pointer wrap)
    cyc(1'b0, 32'h120, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("ff_first_pc",    64'(bus.out_exe_pc), 64'h100);
    chk("ff_first_count", 64'(bus.out_count), 64'd8);
    for (int k = 1; k < 3 * DEPTH; k++)
      cyc(1'b0, 32'h120 + 32'(4 * k), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("ff_last_pc",    64'(bus.out_exe_pc), 64'h15C);
    chk("ff_last_count", 64'(bus.out_count), 64'd8);
    chk("ff_last_stall", 64'(bus.out_fetch_stall), 64'd1);
    for (int k = 0; k < DEPTH; k++) cyc(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("drain_pc",    64'(bus.out_exe_pc), 64'h17C);
    chk("drain_count", 64'(bus.out_count), 64'd0);

    // correct taken resolve
    cyc(1'b0, 32'h40, 1'b1, 32'h10, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h10);
    chk("ok_exe_nop", 64'(bus.out_exe_nop), 64'd0);
    chk("ok_pc",      64'(bus.out_exe_pc), 64'h40);
    chk("ok_taken",   64'(bus.out_exe_branch_taken), 64'd1);
    chk("ok_off",     64'(bus.out_exe_branch_offset), 64'h10);
    chk("ok_flush",   64'(bus.out_flush), 64'd0);
    idle();
    chk("ok_idle_nop", 64'(bus.out_exe_nop), 64'd1);

    // direction mispredict with a simultaneous push
    cyc(1'b0, 32'h80, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 32'h84, 1'b0, 32'h0, 1'b0, 1'b1, 32'h20);
    chk("dm_flush",    64'(bus.out_flush), 64'd1);
    chk("dm_flush_pc", 64'(bus.out_flush_pc), 64'hA0);
    chk("dm_count",    64'(bus.out_count), 64'd0);
    chk("dm_stall0",   64'(bus.out_fetch_stall), 64'd1);
    cyc(1'b0, 32'h88, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("dm_pulse",    64'(bus.out_flush), 64'd0);
    chk("dm_stall1",   64'(bus.out_fetch_stall), 64'd1);
    chk("dm_no_uf",    64'(bus.out_underflow), 64'd0);
    cyc(1'b0, 32'h8C, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("dm_stall2",   64'(bus.out_fetch_stall), 64'd0);
    chk("dm_discard",  64'(bus.out_count), 64'd0);

    // not-taken redirect wrapping past 2^32
    cyc(1'b0, 32'hFFFF_FFFC, 1'b1, 32'h8, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("wrap_flush",    64'(bus.out_flush), 64'd1);
    chk("wrap_flush_pc", 64'(bus.out_flush_pc), 64'h0);
    idle(); idle();

    // offset mispredict
    cyc(1'b0, 32'h200, 1'b1, 32'h10, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h30);
    chk("om_flush",    64'(bus.out_flush), 64'd1);
    chk("om_flush_pc", 64'(bus.out_flush_pc), 64'h230);
    idle(); idle();

    // underflow
    cyc(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4);
    chk("uf_pulse",   64'(bus.out_underflow), 64'd1);
    chk("uf_exe_nop", 64'(bus.out_exe_nop), 64'd1);
`ifdef BP_RESOLVE_STATS_EN
    chk("uf_cnt",      64'(bus.out_underflow_cnt), 64'd1);
    chk("wrong_cnt",   64'(bus.out_pred_wrong_cnt), 64'd3);
    chk("correct_cnt", 64'(bus.out_pred_correct_cnt), 64'd33);
`endif
    idle();
    chk("uf_end", 64'(bus.out_underflow), 64'd0);

    // asynchronous reset mid-stream
    cyc(1'b0, 32'h300, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 32'h304, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("pre_rst_nop",   64'(bus.out_exe_nop), 64'd0);
    chk("pre_rst_count", 64'(bus.out_count), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 64'(bus.out_count), 64'd0);
    chk("mid_rst_nop",   64'(bus.out_exe_nop), 64'd1);
    chk("mid_rst_pc",    64'(bus.out_exe_pc), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    chk("post_rst_count", 64'(bus.out_count), 64'd0);
    cyc(1'b0, 32'h400, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("post_rst_push", 64'(bus.out_count), 64'd1);
    cyc(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("post_rst_pc", 64'(bus.out_exe_pc), 64'h400);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
